mem_port_arbiter: RTL and testbench

Shares the core's single memory port between the fetch stage (instruction reads) and the MEM stage (data loads/stores). It accepts one transaction at a time from either requester and issues it to memory with a req/gnt/rvalid handshake. It routes the response back to the owner, alternates priority under contention, and aborts transactions that exceed a timeout. It sits between the pipeline's fetch/MEM stages and the memory interface.

---
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the MEM stage: one
// transaction in flight, alternating priority, response routing and timeout abort.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ready_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_ready_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic        OWN_IF = 1'b0;
  localparam logic        OWN_D  = 1'b1;
  localparam int unsigned TO_M1  = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [7:0]  TO_LAST = TO_M1[7:0];
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);

  state_t      r_state, w_next;
  logic        r_owner, r_last;
  logic [7:0]  r_cnt;
  logic        r_mem_req, r_mem_we;
  logic [31:0] r_mem_addr, r_mem_wdata;
  logic [31:0] r_if_rdata, r_d_rdata;
  logic        r_if_rvalid, r_d_rvalid, r_timeout;

  logic        w_gnt_if, w_gnt_d, w_accept, w_to, w_resp_mem, w_resp_to;
  logic [31:0] w_resp_data;

  // Under contention the requester not served last wins.
  always_comb begin
    w_gnt_d  = d_req_i & (~if_req_i | (r_last == OWN_IF));
    w_gnt_if = if_req_i & ~w_gnt_d;
    w_accept = rst_n & (r_state == S_IDLE) & (w_gnt_if | w_gnt_d);
    w_to     = TO_EN && (r_cnt == TO_LAST) &&
               ((r_state == S_ISSUE) || (r_state == S_WAIT));
  end

  assign if_ready_o = rst_n & (r_state == S_IDLE) & w_gnt_if;
  assign d_ready_o  = rst_n & (r_state == S_IDLE) & w_gnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_resp_mem = 1'b0;
    w_resp_to  = 1'b0;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_ISSUE;
      // A grant landing on the final counting cycle is still aborted: the
      // response could only arrive after the budget has expired.
      S_ISSUE: begin
        if (w_to) begin
          w_next    = S_RESP;
          w_resp_to = 1'b1;
        end else if (mem_gnt_i) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          w_next     = S_RESP;
          w_resp_mem = 1'b1;
        end else if (w_to) begin
          w_next    = S_RESP;
          w_resp_to = 1'b1;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_resp_data = w_resp_mem ? mem_rdata_i : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner     <= OWN_IF;
      r_last      <= OWN_IF;
      r_cnt       <= 8'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
      r_if_rdata  <= 32'h0;
      r_d_rdata   <= 32'h0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_timeout   <= 1'b0;
      if (w_accept) begin
        r_owner     <= w_gnt_d ? OWN_D : OWN_IF;
        r_mem_req   <= 1'b1;
        r_mem_we    <= w_gnt_d & d_we_i;
        r_mem_addr  <= w_gnt_d ? d_addr_i : if_addr_i;
        r_mem_wdata <= w_gnt_d ? d_wdata_i : 32'h0;
        r_cnt       <= 8'd0;
      end
      if ((r_state == S_ISSUE) || (r_state == S_WAIT))
        r_cnt <= r_cnt + 8'd1;
      if ((r_state == S_ISSUE) && (w_next != S_ISSUE))
        r_mem_req <= 1'b0;
      if (w_resp_mem || w_resp_to) begin
        r_timeout <= w_resp_to;
        if (r_owner == OWN_D) begin
          r_d_rdata  <= w_resp_data;
          r_d_rvalid <= 1'b1;
        end else begin
          r_if_rdata  <= w_resp_data;
          r_if_rvalid <= 1'b1;
        end
      end
      if (r_state == S_RESP)
        r_last <= r_owner;
    end
  end

  assign if_rvalid_o = r_if_rvalid;
  assign if_rdata_o  = r_if_rdata;
  assign d_rvalid_o  = r_d_rvalid;
  assign d_rdata_o   = r_d_rdata;
  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign busy_o      = (r_state != S_IDLE);
  assign timeout_o   = r_timeout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model (one instance at default timeout, one at 4).
module tb_mem_port_arbiter;

  logic        clk, rst_n;
  logic        if_req_i, d_req_i, d_we_i, mem_gnt_i, mem_rvalid_i;
  logic [31:0] if_addr_i, d_addr_i, d_wdata_i, mem_rdata_i;

  logic        if_ready_o, if_rvalid_o, d_ready_o, d_rvalid_o;
  logic        mem_req_o, mem_we_o, busy_o, timeout_o;
  logic [31:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;

  logic        if_ready_4, if_rvalid_4, d_ready_4, d_rvalid_4;
  logic        mem_req_4, mem_we_4, busy_4, timeout_4;
  logic [31:0] if_rdata_4, d_rdata_4, mem_addr_4, mem_wdata_4;

  int n_chk = 0;
  int n_fail = 0;

  mem_port_arbiter u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ready_o(if_ready_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_ready_o(d_ready_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  mem_port_arbiter #(.TIMEOUT_CYCLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ready_o(if_ready_4),
    .if_rvalid_o(if_rvalid_4), .if_rdata_o(if_rdata_4),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_ready_o(d_ready_4), .d_rvalid_o(d_rvalid_4), .d_rdata_o(d_rdata_4),
    .mem_req_o(mem_req_4), .mem_we_o(mem_we_4), .mem_addr_o(mem_addr_4),
    .mem_wdata_o(mem_wdata_4), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .busy_o(busy_4), .timeout_o(timeout_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    if_req_i = 0; if_addr_i = 0; d_req_i = 0; d_we_i = 0; d_addr_i = 0;
    d_wdata_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    clear_inputs();
    rst_n = 0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    if_req_i = 1; d_req_i = 1;
    #12;
    n_chk++;
    if ({if_ready_o, d_ready_o, if_ready_4, d_ready_4} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b want 0000", {if_ready_o, d_ready_o, if_ready_4, d_ready_4});
    end
    n_chk++;
    if ({if_rvalid_o, if_rdata_o, d_rvalid_o, d_rdata_o, mem_req_o, mem_we_o,
         mem_addr_o, mem_wdata_o, busy_o, timeout_o} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: some output nonzero during reset");
    end
    @(posedge clk); #1;
    if_req_i = 0; d_req_i = 0; rst_n = 1;
    @(negedge clk);
    n_chk++;
    if ({busy_o, mem_req_o} !== 2'b00) begin
      n_fail++; $display("FAIL reset_release: busy/req %b want 00", {busy_o, mem_req_o});
    end
  endtask

  task automatic test_single_fetch(input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    if_req_i = 1; if_addr_i = addr;
    @(negedge clk);
    n_chk++;
    if ({if_ready_o, d_ready_o} !== 2'b10) begin
      n_fail++; $display("FAIL fetch_ready: got %b want 10", {if_ready_o, d_ready_o});
    end
    @(posedge clk); #1;
    if_req_i = 0; if_addr_i = 32'hFFFF_0000; mem_gnt_i = 1;
    @(negedge clk);
    n_chk++;
    if ({mem_req_o, mem_we_o, mem_addr_o} !== {1'b1, 1'b0, addr}) begin
      n_fail++; $display("FAIL fetch_issue: req=%b we=%b addr=%h want 1 0 %h", mem_req_o, mem_we_o, mem_addr_o, addr);
    end
    @(posedge clk); #1;
    mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = data;
    @(negedge clk);
    n_chk++;
    if ({mem_req_o, if_rvalid_o} !== 2'b00) begin
      n_fail++; $display("FAIL fetch_wait: req/rvalid %b want 00", {mem_req_o, if_rvalid_o});
    end
    @(posedge clk); #1;
    mem_rvalid_i = 0; mem_rdata_i = 0;
    @(negedge clk);
    n_chk++;
    if ({if_rvalid_o, if_rdata_o, d_rvalid_o} !== {1'b1, data, 1'b0}) begin
      n_fail++; $display("FAIL fetch_resp: rvalid=%b rdata=%h d_rvalid=%b want 1 %h 0", if_rvalid_o, if_rdata_o, d_rvalid_o, data);
    end
    @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({if_rvalid_o, busy_o} !== 2'b00) begin
      n_fail++; $display("FAIL fetch_done: rvalid/busy %b want 00", {if_rvalid_o, busy_o});
    end
  endtask

  task automatic test_store();
    @(posedge clk); #1;
    d_req_i = 1; d_we_i = 1; d_addr_i = 32'h2000; d_wdata_i = 32'h12345678;
    @(negedge clk);
    n_chk++;
    if ({if_ready_o, d_ready_o} !== 2'b01) begin
      n_fail++; $display("FAIL store_ready: got %b want 01", {if_ready_o, d_ready_o});
    end
    @(posedge clk); #1;
    d_req_i = 0; d_we_i = 0; d_addr_i = 32'hBAD0; d_wdata_i = 0;
    for (int c = 1; c <= 4; c++) begin
      mem_gnt_i = (c == 4);
      @(negedge clk);
      n_chk++;
      if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {1'b1, 1'b1, 32'h2000, 32'h12345678}) begin
        n_fail++; $display("FAIL store_hold c%0d: req=%b we=%b addr=%h wdata=%h", c, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o);
      end
      @(posedge clk); #1;
    end
    mem_gnt_i = 0;
    @(negedge clk);
    n_chk++;
    if ({mem_req_o, d_rvalid_o} !== 2'b00) begin
      n_fail++; $display("FAIL store_wait: req/rvalid %b want 00", {mem_req_o, d_rvalid_o});
    end
    @(posedge clk); #1;
    mem_rvalid_i = 1;
    @(negedge clk);
    n_chk++;
    if (d_rvalid_o !== 1'b0) begin
      n_fail++; $display("FAIL store_early: d_rvalid=%b want 0", d_rvalid_o);
    end
    @(posedge clk); #1;
    mem_rvalid_i = 0;
    @(negedge clk);
    n_chk++;
    if ({d_rvalid_o, if_rvalid_o} !== 2'b10) begin
      n_fail++; $display("FAIL store_ack: d/if rvalid %b want 10", {d_rvalid_o, if_rvalid_o});
    end
    @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({d_rvalid_o, busy_o} !== 2'b00) begin
      n_fail++; $display("FAIL store_once: rvalid/busy %b want 00", {d_rvalid_o, busy_o});
    end
  endtask

  task automatic test_contention();
    int acc, last_acc;
    bit pend_rv;
    logic exp_d;
    acc = 0; last_acc = -1; pend_rv = 0;
    do_reset();
    if_req_i = 1; d_req_i = 1; if_addr_i = 32'h40; d_addr_i = 32'h80;
    for (int cyc = 0; cyc < 60 && acc < 12; cyc++) begin
      @(negedge clk);
      n_chk++;
      if (if_ready_o && d_ready_o) begin
        n_fail++; $display("FAIL contention_dual: both ready at cycle %0d", cyc);
      end
      if (if_ready_o || d_ready_o) begin
        exp_d = (acc % 2 == 0);
        n_chk++;
        if (d_ready_o !== exp_d) begin
          n_fail++; $display("FAIL contention_order #%0d: d_ready=%b want %b", acc, d_ready_o, exp_d);
        end
        if (last_acc >= 0) begin
          n_chk++;
          if (cyc - last_acc != 4) begin
            n_fail++; $display("FAIL contention_spacing: %0d cycles want 4", cyc - last_acc);
          end
        end
        last_acc = cyc; acc++;
      end
      @(posedge clk); #1;
      mem_rvalid_i = pend_rv; pend_rv = 0;
      mem_gnt_i = mem_req_o;
      if (mem_req_o) pend_rv = 1;
    end
    n_chk++;
    if (acc != 12) begin
      n_fail++; $display("FAIL contention_count: %0d accepts want 12", acc);
    end
    if_req_i = 0; d_req_i = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      mem_rvalid_i = pend_rv; pend_rv = 0;
      mem_gnt_i = mem_req_o;
      if (mem_req_o) pend_rv = 1;
    end
    mem_gnt_i = 0; mem_rvalid_i = 0;
  endtask

  task automatic test_random();
    bit          p_if, p_d, we_d, own_d, last_d, ewe;
    logic [31:0] a_if, a_d, wd_d, ea, ed, e_if_rd, e_d_rd;
    int          g, r;
    do_reset();
    p_if = 0; p_d = 0; we_d = 0; last_d = 0; e_if_rd = 0; e_d_rd = 0;
    a_if = 0; a_d = 0; wd_d = 0;
    for (int t = 0; t < 40; t++) begin
      if (!p_if && $urandom_range(0, 1) == 1) begin p_if = 1; a_if = $urandom; end
      if (!p_d && ($urandom_range(0, 1) == 1 || !p_if)) begin
        p_d = 1; a_d = $urandom; wd_d = $urandom; we_d = 1'($urandom_range(0, 1));
      end
      if_req_i = p_if; if_addr_i = a_if;
      d_req_i = p_d; d_addr_i = a_d; d_wdata_i = wd_d; d_we_i = we_d;
      own_d = p_d && (!p_if || !last_d);
      ea = own_d ? a_d : a_if;
      ewe = own_d & we_d;
      g = $urandom_range(0, 2); r = $urandom_range(0, 2); ed = $urandom;
      @(negedge clk);
      n_chk++;
      if ({if_ready_o, d_ready_o} !== {!own_d, own_d}) begin
        n_fail++; $display("FAIL rand_grant t%0d: if/d ready %b want %b", t, {if_ready_o, d_ready_o}, {!own_d, own_d});
      end
      @(posedge clk); #1;
      if (own_d) begin p_d = 0; d_req_i = 0; d_addr_i = $urandom; end
      else begin p_if = 0; if_req_i = 0; if_addr_i = $urandom; end
      mem_gnt_i = (g == 0);
      for (int c = 0; c <= g; c++) begin
        @(negedge clk);
        n_chk++;
        if ({mem_req_o, mem_we_o, mem_addr_o} !== {1'b1, ewe, ea} || (own_d && mem_wdata_o !== wd_d)) begin
          n_fail++; $display("FAIL rand_issue t%0d: req=%b we=%b addr=%h wdata=%h want 1 %b %h", t, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, ewe, ea);
        end
        @(posedge clk); #1;
        mem_gnt_i = (c + 1 == g);
      end
      for (int c = 0; c < r; c++) begin
        @(negedge clk);
        n_chk++;
        if ({mem_req_o, if_rvalid_o, d_rvalid_o} !== 3'b000) begin
          n_fail++; $display("FAIL rand_wait t%0d: req/if/d %b want 000", t, {mem_req_o, if_rvalid_o, d_rvalid_o});
        end
        @(posedge clk); #1;
      end
      mem_rvalid_i = 1; mem_rdata_i = ed;
      @(posedge clk); #1;
      mem_rvalid_i = 0;
      if (own_d) e_d_rd = ed; else e_if_rd = ed;
      @(negedge clk);
      n_chk++;
      if ({if_rvalid_o, d_rvalid_o, if_rdata_o, d_rdata_o, timeout_o} !== {!own_d, own_d, e_if_rd, e_d_rd, 1'b0}) begin
        n_fail++; $display("FAIL rand_resp t%0d: rv if/d %b%b rdata if/d %h %h to=%b want %b%b %h %h 0", t,
          if_rvalid_o, d_rvalid_o, if_rdata_o, d_rdata_o, timeout_o, !own_d, own_d, e_if_rd, e_d_rd);
      end
      last_d = own_d;
      @(posedge clk); #1;
    end
    if_req_i = 0; d_req_i = 0;
    @(negedge clk);
    n_chk++;
    if ({busy_o, if_ready_o, d_ready_o} !== 3'b000) begin
      n_fail++; $display("FAIL rand_idle: busy/ready %b want 000", {busy_o, if_ready_o, d_ready_o});
    end
  endtask

  task automatic test_collision();
    @(posedge clk); #1;
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h3000;
    @(negedge clk);
    n_chk++;
    if (d_ready_4 !== 1'b1) begin
      n_fail++; $display("FAIL coll_ready: got %b want 1", d_ready_4);
    end
    @(posedge clk); #1;
    d_req_i = 0; mem_gnt_i = 1;
    @(posedge clk); #1;
    mem_gnt_i = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_rvalid_i = 1; mem_rdata_i = 32'hA5A5A5A5;
    @(negedge clk);
    n_chk++;
    if ({d_rvalid_4, timeout_4} !== 2'b00) begin
      n_fail++; $display("FAIL coll_early: rvalid/timeout %b want 00", {d_rvalid_4, timeout_4});
    end
    @(posedge clk); #1;
    mem_rvalid_i = 0; mem_rdata_i = 0;
    @(negedge clk);
    n_chk++;
    if ({d_rvalid_4, d_rdata_4, timeout_4} !== {1'b1, 32'hA5A5A5A5, 1'b0}) begin
      n_fail++; $display("FAIL coll_resp: rvalid=%b rdata=%h timeout=%b want 1 a5a5a5a5 0", d_rvalid_4, d_rdata_4, timeout_4);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    @(posedge clk); #1;
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h3004;
    @(negedge clk);
    n_chk++;
    if (d_ready_4 !== 1'b1) begin
      n_fail++; $display("FAIL to_ready: got %b want 1", d_ready_4);
    end
    @(posedge clk); #1;
    d_req_i = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      n_chk++;
      if ({mem_req_4, timeout_4, d_rvalid_4} !== 3'b100) begin
        n_fail++; $display("FAIL to_count c%0d: req/to/rvalid %b want 100", c, {mem_req_4, timeout_4, d_rvalid_4});
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_chk++;
    if ({timeout_4, d_rvalid_4, d_rdata_4, mem_req_4, if_rvalid_4} !== {1'b1, 1'b1, 32'h0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL to_abort: to=%b rvalid=%b rdata=%h req=%b if_rv=%b want 1 1 0 0 0",
        timeout_4, d_rvalid_4, d_rdata_4, mem_req_4, if_rvalid_4);
    end
    @(posedge clk); #1;
    mem_rvalid_i = 1; mem_rdata_i = 32'hFFFFFFFF;
    @(negedge clk);
    n_chk++;
    if ({busy_4, timeout_4, d_rvalid_4} !== 3'b000) begin
      n_fail++; $display("FAIL to_idle: busy/to/rvalid %b want 000", {busy_4, timeout_4, d_rvalid_4});
    end
    @(posedge clk); #1;
    mem_rvalid_i = 0; mem_rdata_i = 0;
    @(negedge clk);
    n_chk++;
    if ({busy_4, d_rvalid_4, if_rvalid_4, timeout_4, d_rdata_4} !== 36'h0) begin
      n_fail++; $display("FAIL to_stray: busy=%b rv=%b%b to=%b rdata=%h want all 0", busy_4, d_rvalid_4, if_rvalid_4, timeout_4, d_rdata_4);
    end
  endtask

  task automatic test_reset_mid_wait();
    // u_dut is still holding the 0x3004 load in ISSUE; grant it into WAIT.
    @(posedge clk); #1;
    mem_gnt_i = 1;
    @(posedge clk); #1;
    mem_gnt_i = 0;
    @(negedge clk);
    n_chk++;
    if ({busy_o, mem_req_o} !== 2'b10) begin
      n_fail++; $display("FAIL rst_wait_state: busy/req %b want 10", {busy_o, mem_req_o});
    end
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    n_chk++;
    if ({if_ready_o, if_rvalid_o, if_rdata_o, d_ready_o, d_rvalid_o, d_rdata_o, mem_req_o,
         mem_we_o, mem_addr_o, mem_wdata_o, busy_o, timeout_o} !== '0) begin
      n_fail++; $display("FAIL rst_mid_outputs: d_rdata=%h addr=%h busy=%b want all 0", d_rdata_o, mem_addr_o, busy_o);
    end
    @(posedge clk); #1;
    mem_rvalid_i = 1; mem_rdata_i = 32'h777;
    @(posedge clk); #1;
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_chk++;
      if ({if_rvalid_o, d_rvalid_o, busy_o, timeout_o} !== 4'b0000) begin
        n_fail++; $display("FAIL rst_late c%0d: rv if/d busy to %b want 0000", c, {if_rvalid_o, d_rvalid_o, busy_o, timeout_o});
      end
      @(posedge clk); #1;
      mem_rvalid_i = 0; mem_rdata_i = 0;
    end
    test_single_fetch(32'h400, 32'hCAFEF00D);
  endtask

  initial begin
    test_reset();
    test_single_fetch(32'h100, 32'hDEADBEEF);
    test_store();
    test_contention();
    test_random();
    do_reset();
    test_collision();
    test_timeout();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
